// File: rtl/ex_mem_stage_if.sv
// Bundles the ID/EX inputs, the forwarding controls and the EX/MEM results
// that pass between the execute stage and the rest of the pipeline.
interface ex_mem_stage_if;
    // Pipeline register control and ID/EX payload
    logic [1:0]  Control;
    logic [31:0] Data1_in;
    logic [31:0] Data2_in;
    logic [31:0] PC_in;
    logic [31:0] Imm32_in;
    logic [4:0]  Rt_in;
    logic [4:0]  Rd_in;
    logic [4:0]  Shamt_in;
    logic [4:0]  ALUCtrl_in;
    logic        Sign_in;
    logic        Branch_in;
    logic        RegWrite_in;
    logic [1:0]  RegDst_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [1:0]  MemtoReg_in;
    logic        ALUSrc1_in;
    logic        ALUSrc2_in;
    // Forwarding
    logic [1:0]  FwdA;
    logic [1:0]  FwdB;
    logic [31:0] WB_Data_in;
    // Results
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic [31:0] ALUOut_out;
    logic [31:0] WriteData_out;
    logic [4:0]  WriteReg_out;
    logic [31:0] PC_out;
    logic        RegWrite_out;
    logic        MemRead_out;
    logic        MemWrite_out;
    logic [1:0]  MemtoReg_out;

    // Execute stage side: consumes the payload, produces results
    modport slave (
        input  Control, Data1_in, Data2_in, PC_in, Imm32_in, Rt_in, Rd_in,
               Shamt_in, ALUCtrl_in, Sign_in, Branch_in, RegWrite_in,
               RegDst_in, MemRead_in, MemWrite_in, MemtoReg_in,
               ALUSrc1_in, ALUSrc2_in, FwdA, FwdB, WB_Data_in,
        output Branch_taken, Branch_target, ALUOut_out, WriteData_out,
               WriteReg_out, PC_out, RegWrite_out, MemRead_out,
               MemWrite_out, MemtoReg_out
    );

    // Pipeline side: drives the payload, observes results
    modport master (
        output Control, Data1_in, Data2_in, PC_in, Imm32_in, Rt_in, Rd_in,
               Shamt_in, ALUCtrl_in, Sign_in, Branch_in, RegWrite_in,
               RegDst_in, MemRead_in, MemWrite_in, MemtoReg_in,
               ALUSrc1_in, ALUSrc2_in, FwdA, FwdB, WB_Data_in,
        input  Branch_taken, Branch_target, ALUOut_out, WriteData_out,
               WriteReg_out, PC_out, RegWrite_out, MemRead_out,
               MemWrite_out, MemtoReg_out
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, ALU,
// combinational branch resolution, and the registered hand-off to MEM.
// Branch op codes: 10000 BEQ, 10001 BNE, 10010 BLEZ, 10011 BGTZ, 10100 BLTZ.
module ex_mem_stage #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] RA_ADDR = 5'd31
) (
    input logic            clk,
    input logic            reset,
    ex_mem_stage_if.slave  bus
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOR  = 5'b00101;
    localparam logic [4:0] OP_SLT  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BNE  = 5'b10001;
    localparam logic [4:0] OP_BLEZ = 5'b10010;
    localparam logic [4:0] OP_BGTZ = 5'b10011;
    localparam logic [4:0] OP_BLTZ = 5'b10100;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // ALU result for one op code; branch, NULL and undefined codes give zero
    function automatic logic [WIDTH-1:0] alu_f(
        input logic [4:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sign
    );
        logic [WIDTH-1:0] r;
        logic             lt;
        r  = ZERO_W;
        lt = 1'b0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_SLT: begin
                if (sign) begin
                    lt = ($signed(a) < $signed(b));
                end else begin
                    lt = (a < b);
                end
                r = {{(WIDTH-1){1'b0}}, lt};
            end
            OP_SLL: r = b << a[4:0];
            OP_SRL: r = b >> a[4:0];
            OP_SRA: r = $unsigned($signed(b) >>> a[4:0]);
            default: r = ZERO_W;
        endcase
        return r;
    endfunction

    // Signed branch condition on the forwarded operands; non-branch codes never take
    function automatic logic branch_cond_f(
        input logic [4:0]       op,
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb
    );
        logic c;
        c = 1'b0;
        case (op)
            OP_BEQ:  c = (fa == fb);
            OP_BNE:  c = (fa != fb);
            OP_BLEZ: c = fa[WIDTH-1] | (fa == ZERO_W);
            OP_BGTZ: c = ~fa[WIDTH-1] & (fa != ZERO_W);
            OP_BLTZ: c = fa[WIDTH-1];
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Pipeline register state
    logic [WIDTH-1:0] alu_out_q,    alu_out_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;
    logic [4:0]       write_reg_q,  write_reg_d;
    logic [WIDTH-1:0] pc_q,         pc_d;
    logic             reg_write_q,  reg_write_d;
    logic             mem_read_q,   mem_read_d;
    logic             mem_write_q,  mem_write_d;
    logic [1:0]       mem_to_reg_q, mem_to_reg_d;

    // Combinational execute values
    logic [WIDTH-1:0] fwd_a_s;
    logic [WIDTH-1:0] fwd_b_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] alu_result_s;
    logic [4:0]       dest_reg_s;
    logic             branch_taken_s;
    logic [WIDTH-1:0] branch_target_s;

    // Forwarding mux for operand A; 01 feeds back our own EX/MEM result
    always_comb begin
        fwd_a_s = bus.Data1_in;
        case (bus.FwdA)
            2'b00:   fwd_a_s = bus.Data1_in;
            2'b01:   fwd_a_s = alu_out_q;
            2'b10:   fwd_a_s = bus.WB_Data_in;
            default: fwd_a_s = bus.Data1_in;
        endcase
    end

    // Forwarding mux for operand B, same selection as A
    always_comb begin
        fwd_b_s = bus.Data2_in;
        case (bus.FwdB)
            2'b00:   fwd_b_s = bus.Data2_in;
            2'b01:   fwd_b_s = alu_out_q;
            2'b10:   fwd_b_s = bus.WB_Data_in;
            default: fwd_b_s = bus.Data2_in;
        endcase
    end

    // ALU operand selection: shamt for A on shifts, immediate for B
    always_comb begin
        op_a_s = fwd_a_s;
        op_b_s = fwd_b_s;
        if (bus.ALUSrc1_in) begin
            op_a_s = {{(WIDTH-5){1'b0}}, bus.Shamt_in};
        end else begin
            op_a_s = fwd_a_s;
        end
        if (bus.ALUSrc2_in) begin
            op_b_s = bus.Imm32_in;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    // ALU evaluation and branch resolution
    always_comb begin
        alu_result_s    = alu_f(bus.ALUCtrl_in, op_a_s, op_b_s, bus.Sign_in);
        branch_taken_s  = bus.Branch_in & branch_cond_f(bus.ALUCtrl_in, fwd_a_s, fwd_b_s);
        branch_target_s = bus.PC_in + {bus.Imm32_in[WIDTH-3:0], 2'b00};
    end

    // Destination register select; 11 targets $zero
    always_comb begin
        dest_reg_s = 5'd0;
        case (bus.RegDst_in)
            2'b00:   dest_reg_s = bus.Rt_in;
            2'b01:   dest_reg_s = bus.Rd_in;
            2'b10:   dest_reg_s = RA_ADDR;
            default: dest_reg_s = 5'd0;
        endcase
    end

    // Next pipeline register contents: load, hold, or bubble
    always_comb begin
        alu_out_d    = alu_out_q;
        write_data_d = write_data_q;
        write_reg_d  = write_reg_q;
        pc_d         = pc_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        case (bus.Control)
            2'b00: begin
                alu_out_d    = alu_result_s;
                write_data_d = fwd_b_s;
                write_reg_d  = dest_reg_s;
                pc_d         = bus.PC_in;
                reg_write_d  = bus.RegWrite_in;
                mem_read_d   = bus.MemRead_in;
                mem_write_d  = bus.MemWrite_in;
                mem_to_reg_d = bus.MemtoReg_in;
            end
            2'b01: begin
                alu_out_d    = alu_out_q;
                write_data_d = write_data_q;
                write_reg_d  = write_reg_q;
                pc_d         = pc_q;
                reg_write_d  = reg_write_q;
                mem_read_d   = mem_read_q;
                mem_write_d  = mem_write_q;
                mem_to_reg_d = mem_to_reg_q;
            end
            default: begin
                alu_out_d    = ZERO_W;
                write_data_d = ZERO_W;
                write_reg_d  = 5'd0;
                pc_d         = ZERO_W;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 2'b00;
            end
        endcase
    end

    // EX/MEM register; reset clears immediately and overrides Control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_q    <= ZERO_W;
            write_data_q <= ZERO_W;
            write_reg_q  <= 5'd0;
            pc_q         <= ZERO_W;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 2'b00;
        end else begin
            alu_out_q    <= alu_out_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            pc_q         <= pc_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign bus.Branch_taken  = branch_taken_s;
    assign bus.Branch_target = branch_target_s;
    assign bus.ALUOut_out    = alu_out_q;
    assign bus.WriteData_out = write_data_q;
    assign bus.WriteReg_out  = write_reg_q;
    assign bus.PC_out        = pc_q;
    assign bus.RegWrite_out  = reg_write_q;
    assign bus.MemRead_out   = mem_read_q;
    assign bus.MemWrite_out  = mem_write_q;
    assign bus.MemtoReg_out  = mem_to_reg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes reference-model
// expectations into queues, a negedge monitor pops and compares them.
module tb_ex_mem_stage;

    logic clk;
    logic reset;

    ex_mem_stage_if bus();

    ex_mem_stage #(.WIDTH(32), .RA_ADDR(5'd31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] d1, d2, pc, imm, wb;
        logic [4:0]  rt, rd, shamt, op;
        logic        sign, br, rw, mr, mw, src1, src2;
        logic [1:0]  regdst, mtr, fwda, fwdb;
    } txn_t;

    typedef struct {
        logic [31:0] alu, wd, pc;
        logic [4:0]  wr;
        logic        rw, mr, mw;
        logic [1:0]  mtr;
    } reg_state_t;

    typedef struct {
        logic        taken;
        logic [31:0] target;
    } br_exp_t;

    reg_state_t m_state;     // reference model of the pipeline register
    reg_state_t exp_q[$];
    br_exp_t    br_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic sg);
        int unsigned s;
        s = a[4:0];
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  begin
                if (sg) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                else    return (a < b) ? 32'd1 : 32'd0;
            end
            5'd8:  return b << s;
            5'd9:  return b >> s;
            5'd10: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [4:0] op, input logic [31:0] fa, input logic [31:0] fb);
        int sa;
        sa = int'(fa);
        case (op)
            5'd16: return fa == fb;
            5'd17: return fa != fb;
            5'd18: return sa <= 0;
            5'd19: return sa > 0;
            5'd20: return sa < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] own, input logic [31:0] wb);
        if (sel == 2'b01) return own;
        if (sel == 2'b10) return wb;
        return reg_val;
    endfunction

    function automatic txn_t blank();
        txn_t t;
        t.ctrl = 2'b00; t.d1 = 32'h0; t.d2 = 32'h0; t.pc = 32'h0; t.imm = 32'h0; t.wb = 32'h0;
        t.rt = 5'd0; t.rd = 5'd0; t.shamt = 5'd0; t.op = 5'd0;
        t.sign = 1'b0; t.br = 1'b0; t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.src1 = 1'b0; t.src2 = 1'b0;
        t.regdst = 2'b00; t.mtr = 2'b00; t.fwda = 2'b00; t.fwdb = 2'b00;
        return t;
    endfunction

    function automatic reg_state_t zero_state();
        reg_state_t s;
        s.alu = 32'h0; s.wd = 32'h0; s.pc = 32'h0; s.wr = 5'd0;
        s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.mtr = 2'b00;
        return s;
    endfunction

    // Apply one transaction just after a rising edge and advance the model
    task automatic drive(input txn_t t);
        logic [31:0] fa, fb, a, b;
        br_exp_t     be;
        @(posedge clk);
        #1;
        exp_q.push_back(m_state);
        bus.Control = t.ctrl;     bus.Data1_in = t.d1;    bus.Data2_in = t.d2;
        bus.PC_in = t.pc;         bus.Imm32_in = t.imm;   bus.WB_Data_in = t.wb;
        bus.Rt_in = t.rt;         bus.Rd_in = t.rd;       bus.Shamt_in = t.shamt;
        bus.ALUCtrl_in = t.op;    bus.Sign_in = t.sign;   bus.Branch_in = t.br;
        bus.RegWrite_in = t.rw;   bus.MemRead_in = t.mr;  bus.MemWrite_in = t.mw;
        bus.ALUSrc1_in = t.src1;  bus.ALUSrc2_in = t.src2;
        bus.RegDst_in = t.regdst; bus.MemtoReg_in = t.mtr;
        bus.FwdA = t.fwda;        bus.FwdB = t.fwdb;
        fa = ref_fwd(t.fwda, t.d1, m_state.alu, t.wb);
        fb = ref_fwd(t.fwdb, t.d2, m_state.alu, t.wb);
        a  = t.src1 ? {27'd0, t.shamt} : fa;
        b  = t.src2 ? t.imm : fb;
        be.taken  = t.br & ref_branch(t.op, fa, fb);
        be.target = t.pc + t.imm * 32'd4;
        br_q.push_back(be);
        if (t.ctrl == 2'b00) begin
            m_state.alu = ref_alu(t.op, a, b, t.sign);
            m_state.wd  = fb;
            m_state.pc  = t.pc;
            m_state.wr  = (t.regdst == 2'b00) ? t.rt : (t.regdst == 2'b01) ? t.rd :
                          (t.regdst == 2'b10) ? 5'd31 : 5'd0;
            m_state.rw  = t.rw; m_state.mr = t.mr; m_state.mw = t.mw; m_state.mtr = t.mtr;
        end else if (t.ctrl != 2'b01) begin
            m_state = zero_state();
        end
    endtask

    // Drive, let the edge load it, return at the following negedge with hold selected
    task automatic run_hold(input txn_t t);
        drive(t);
        #14;
        bus.Control = 2'b01;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alu"}, bus.ALUOut_out, 32'h0);
        chk({tag, "_wd"},  bus.WriteData_out, 32'h0);
        chk({tag, "_wr"},  {27'd0, bus.WriteReg_out}, 32'h0);
        chk({tag, "_pc"},  bus.PC_out, 32'h0);
        chk({tag, "_rw"},  {31'd0, bus.RegWrite_out}, 32'h0);
        chk({tag, "_mr"},  {31'd0, bus.MemRead_out}, 32'h0);
        chk({tag, "_mw"},  {31'd0, bus.MemWrite_out}, 32'h0);
        chk({tag, "_mtr"}, {30'd0, bus.MemtoReg_out}, 32'h0);
    endtask

    // Monitor: compare every presented output against the scoreboard
    always @(negedge clk) begin : monitor
        reg_state_t e;
        br_exp_t    be;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_alu", bus.ALUOut_out, e.alu);
            chk("mon_wd",  bus.WriteData_out, e.wd);
            chk("mon_wr",  {27'd0, bus.WriteReg_out}, {27'd0, e.wr});
            chk("mon_pc",  bus.PC_out, e.pc);
            chk("mon_ctl", {28'd0, bus.RegWrite_out, bus.MemRead_out, bus.MemWrite_out, 1'b0},
                           {28'd0, e.rw, e.mr, e.mw, 1'b0});
            chk("mon_mtr", {30'd0, bus.MemtoReg_out}, {30'd0, e.mtr});
        end
        if (br_q.size() > 0) begin
            be = br_q.pop_front();
            chk("mon_br_taken",  {31'd0, bus.Branch_taken}, {31'd0, be.taken});
            chk("mon_br_target", bus.Branch_target, be.target);
        end
    end

    localparam logic [4:0] OPS [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                                        5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd31, 5'd7, 5'd11};

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(3))
            0:       return 32'($urandom_range(15));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(3));
            default: return $urandom;
        endcase
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        int   r;
        t = blank();
        r = $urandom_range(99);
        t.ctrl = (r < 70) ? 2'b00 : (r < 85) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
        t.d1 = rnd_word();
        t.d2 = ($urandom_range(3) == 0) ? t.d1 : rnd_word();
        t.pc = $urandom; t.imm = rnd_word(); t.wb = rnd_word();
        t.rt = 5'($urandom); t.rd = 5'($urandom); t.shamt = 5'($urandom);
        t.op = OPS[$urandom_range(17)];
        t.sign = 1'($urandom); t.br = 1'($urandom); t.rw = 1'($urandom);
        t.mr = 1'($urandom); t.mw = 1'($urandom);
        t.src1 = 1'($urandom); t.src2 = 1'($urandom);
        t.regdst = 2'($urandom); t.mtr = 2'($urandom);
        t.fwda = 2'($urandom); t.fwdb = 2'($urandom);
        return t;
    endfunction

    initial begin : stimulus
        txn_t t;
        reset = 1'b1;
        bus.Control = 2'b01;  bus.Data1_in = 32'h0; bus.Data2_in = 32'h0; bus.PC_in = 32'h0;
        bus.Imm32_in = 32'h0; bus.WB_Data_in = 32'h0; bus.Rt_in = 5'd0; bus.Rd_in = 5'd0;
        bus.Shamt_in = 5'd0;  bus.ALUCtrl_in = 5'd0; bus.Sign_in = 1'b0; bus.Branch_in = 1'b0;
        bus.RegWrite_in = 1'b0; bus.MemRead_in = 1'b0; bus.MemWrite_in = 1'b0;
        bus.ALUSrc1_in = 1'b0; bus.ALUSrc2_in = 1'b0; bus.RegDst_in = 2'b00;
        bus.MemtoReg_in = 2'b00; bus.FwdA = 2'b00; bus.FwdB = 2'b00;
        m_state = zero_state();
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;

        // ADD 5 + 7, then two hold cycles with changing inputs
        t = blank(); t.d1 = 32'd5; t.d2 = 32'd7; t.rt = 5'd3; t.rw = 1'b1;
        run_hold(t);
        chk("add_5_7", bus.ALUOut_out, 32'd12);
        for (int i = 0; i < 2; i++) begin
            t = rnd_txn(); t.ctrl = 2'b01;
            drive(t);
        end
        #14;
        bus.Control = 2'b01;
        chk("hold_alu", bus.ALUOut_out, 32'd12);
        chk("hold_wd",  bus.WriteData_out, 32'd7);
        chk("hold_wr",  {27'd0, bus.WriteReg_out}, 32'd3);

        t = blank(); t.d1 = 32'd3; t.d2 = 32'd5; t.op = 5'd1;
        run_hold(t);
        chk("sub_3_5", bus.ALUOut_out, 32'hFFFF_FFFE);

        t = blank(); t.d1 = 32'hFFFF_FFFF; t.d2 = 32'd1; t.op = 5'd6; t.sign = 1'b1;
        run_hold(t);
        chk("slt_signed", bus.ALUOut_out, 32'd1);
        t.sign = 1'b0;
        run_hold(t);
        chk("slt_unsigned", bus.ALUOut_out, 32'd0);

        t = blank(); t.d2 = 32'h8000_0000; t.shamt = 5'd4; t.src1 = 1'b1; t.op = 5'd10;
        run_hold(t);
        chk("sra", bus.ALUOut_out, 32'hF800_0000);
        t.op = 5'd9;
        run_hold(t);
        chk("srl", bus.ALUOut_out, 32'h0800_0000);

        // Forwarding from own register (0x10) and from write-back (0x20)
        t = blank(); t.d1 = 32'h8; t.d2 = 32'h8;
        run_hold(t);
        t = blank(); t.fwda = 2'b01; t.fwdb = 2'b10; t.wb = 32'h20; t.d1 = 32'h111; t.d2 = 32'h222;
        run_hold(t);
        chk("fwd_add", bus.ALUOut_out, 32'h30);
        chk("fwd_wd",  bus.WriteData_out, 32'h20);

        // BEQ taken with negative offset
        t = blank(); t.d1 = 32'd9; t.d2 = 32'd9; t.pc = 32'h0040_0010; t.imm = 32'hFFFF_FFFF;
        t.br = 1'b1; t.op = 5'd16;
        drive(t);
        #4;
        chk("beq_taken",  {31'd0, bus.Branch_taken}, 32'd1);
        chk("beq_target", bus.Branch_target, 32'h0040_000C);
        #10;
        bus.Control = 2'b01;

        // BGTZ with zero operand
        t = blank(); t.d1 = 32'd0; t.br = 1'b1; t.op = 5'd19; t.pc = 32'h100;
        drive(t);
        #4;
        chk("bgtz_zero", {31'd0, bus.Branch_taken}, 32'd0);
        #10;
        bus.Control = 2'b01;

        // jal
        t = blank(); t.regdst = 2'b10; t.mtr = 2'b10; t.rw = 1'b1; t.pc = 32'h0040_0100; t.op = 5'd31;
        run_hold(t);
        chk("jal_wr",  {27'd0, bus.WriteReg_out}, 32'd31);
        chk("jal_pc",  bus.PC_out, 32'h0040_0100);
        chk("jal_mtr", {30'd0, bus.MemtoReg_out}, 32'd2);

        // Reset pulse between clock edges
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_pulse");
        #1;
        reset = 1'b0;
        m_state = zero_state();

        // Store then bubble
        t = blank(); t.d1 = 32'd1; t.d2 = 32'd1; t.mw = 1'b1; t.rw = 1'b1; t.mr = 1'b1; t.pc = 32'h44;
        run_hold(t);
        chk("pre_bubble_mw", {31'd0, bus.MemWrite_out}, 32'd1);
        t.ctrl = 2'b10;
        run_hold(t);
        check_all_zero("bubble");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(rnd_txn());
        end
        #4;
        bus.Control = 2'b01;
        repeat (3) @(negedge clk);
        chk("drain_reg_q", 32'(exp_q.size()), 32'd0);
        chk("drain_br_q",  32'(br_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs: operands, immediate, shamt, ALUCtrl, Sign, control bits.
- Applies forwarding, runs the ALU, resolves branches combinationally, and registers results for the MEM stage.
- Register update is governed by the shared 2-bit Control code: 00 load, 01 hold, 10/11 bubble.

Parameters:
- WIDTH, 32, datapath width (fixed at 32; shift amount uses bits [4:0]).
- RA_ADDR, 5'd31, destination register when RegDst = 10 (jal).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Control  in  2  00 load, 01 hold, 10/11 bubble (zero)
- Data1_in  in  32  rs register data from ID/EX
- Data2_in  in  32  rt register data from ID/EX
- PC_in  in  32  PC+4 of the instruction
- Imm32_in  in  32  extended immediate
- Rt_in  in  5  rt field
- Rd_in  in  5  rd field
- Shamt_in  in  5  shift amount
- ALUCtrl_in  in  5  ALU op code
- Sign_in  in  1  1 = signed compare for SLT
- Branch_in  in  1  branch instruction
- RegWrite_in  in  1  RegWrite from ID/EX
- RegDst_in  in  2  RegDst from ID/EX
- MemRead_in  in  1  MemRead from ID/EX
- MemWrite_in  in  1  MemWrite from ID/EX
- MemtoReg_in  in  2  MemtoReg from ID/EX
- ALUSrc1_in  in  1  ALUSrc1 from ID/EX
- ALUSrc2_in  in  1  ALUSrc2 from ID/EX
- FwdA  in  2  operand-A forwarding select
- FwdB  in  2  operand-B forwarding select
- WB_Data_in  in  32  write-back data for forwarding
- Branch_taken  out  1  combinational branch decision
- Branch_target  out  32  combinational branch target
- ALUOut_out  out  32  registered ALU result
- WriteData_out  out  32  registered store data
- WriteReg_out  out  5  registered destination register
- PC_out  out  32  registered PC+4
- RegWrite_out  out  1  registered control bit
- MemRead_out  out  1  registered control bit
- MemWrite_out  out  1  registered control bit
- MemtoReg_out  out  2  registered control bit

Behaviour:
- Reset: all registered outputs are 0, asynchronous, taking effect immediately on reset assertion.
- Forwarded values:
  - fA = FwdA 00: Data1_in; 01: ALUOut_out (own EX/MEM value); 10: WB_Data_in; 11: Data1_in.
  - fB: same selection applied to Data2_in.
- ALU operands:
  - A = ALUSrc1_in ? {27'b0, Shamt_in} : fA.
  - B = ALUSrc2_in ? Imm32_in : fB.
- ALU result by ALUCtrl:
  - 00000 ADD = A+B; 00001 SUB = A-B; both mod 2^32, no overflow trap.
  - 00010 AND; 00011 OR; 00100 XOR; 00101 NOR.
  - 00110 SLT = {31'b0, A<B}; signed if Sign_in = 1, otherwise unsigned.
  - 01000 SLL = B<<A[4:0]; 01001 SRL = B>>A[4:0] logical; 01010 SRA = B>>>A[4:0] arithmetic.
  - Branch codes 100xx, 10100 and NULL 11111, plus any undefined code: result 0.
- Branch condition (on fA/fB, always signed):
  - BEQ fA==fB; BNE fA!=fB.
  - BLEZ fA<=0; BGTZ fA>0; BLTZ fA<0.
- Branch_taken = Branch_in & condition. Independent of Control; it is 0 when ALUCtrl is not a branch code.
- Branch_target = PC_in + (Imm32_in<<2), mod 2^32.
- Destination: RegDst 00 → Rt_in, 01 → Rd_in, 10 → RA_ADDR, 11 → 0.
- Store data: WriteData = fB.
- Clock edge, Control = 00: load ALU result, fB, destination, PC_in and all control bits. Latency is 1 cycle.
- Clock edge, Control = 01: every register holds. Forwarding select 01 still reads the held value.
- Clock edge, Control = 10/11: bubble; all registers load 0, so RegWrite/MemRead/MemWrite are 0.
- Reset asserted mid-operation overrides Control on the same edge; the first load happens on the first clk edge after reset deassertion.

Test Plan:
- Reset: after reset, all registered outputs are 0. With Control = 00, ADD A=5, B=7 → ALUOut_out = 12 after one edge.
- ALU ops:
  - SUB 3-5 → 0xFFFFFFFE.
  - SLT 0xFFFFFFFF vs 1: Sign=1 → 1; Sign=0 → 0.
  - SRA B=0x80000000, shamt 4 (ALUSrc1=1) → 0xF8000000; SRL → 0x08000000.
- Forwarding: ALUOut_out = 0x10, FwdA = 01, FwdB = 10 with WB_Data_in = 0x20, ADD → 0x30; WriteData_out = 0x20.
- Branches:
  - BEQ, fA = fB = 9, PC_in = 0x00400010, Imm32 = 0xFFFFFFFF → Branch_taken = 1, Branch_target = 0x0040000C.
  - BGTZ with fA = 0 → Branch_taken = 0.
- Hold and bubble:
  - Control = 01 for 2 cycles with changing inputs → outputs unchanged.
  - Control = 10 → all outputs 0, MemWrite_out = 0.
- Write-register and reset corner cases:
  - jal (RegDst = 10, MemtoReg = 10) → WriteReg_out = 31, PC_out = PC_in.
  - Reset pulse between edges → outputs clear without waiting for a clock edge.
